xcorr_engine: RTL and testbench
===============================

Name: xcorr_engine

Overview:
Parametrised streaming cross-correlation engine, the successor of the fixed 64x1024 load_data core.
- Accepts a PAT_LEN-sample pattern g, then a SIG_LEN-sample signal f, over one valid/ready stream.
- Computes C[k] = sum over i of f[k+i]*g[i] for k = 0..SIG_LEN-PAT_LEN.
- Reports the maximum C and its location for the top-level controller/LCD formatter.
- Adds generic widths and lengths, signed/unsigned mode, input backpressure and restart without reset.

Parameters:
DATA_W, 8, sample width in bits
PAT_LEN, 64, pattern length M; must satisfy 2 <= M <= SIG_LEN
SIG_LEN, 1024, signal length N
SIGNED, 1, 1 = two's-complement samples and products; 0 = unsigned
ACC_W, 2*DATA_W+$clog2(PAT_LEN)+1, accumulator/result width (derived; do not override smaller)
LOC_W, $clog2(SIG_LEN-PAT_LEN+1)+1, location width (derived)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
start  in  1  one-cycle pulse; begins a run from S_IDLE or S_DONE
in_valid  in  1  in_data valid
in_data  in  DATA_W  pattern samples, then signal samples, in index order
in_ready  out  1  engine accepts in_data this cycle
busy  out  1  high in every state except S_IDLE and S_DONE
done  out  1  high while results are valid (S_DONE)
max_val  out  ACC_W  maximum C[k], sign-extended per SIGNED
max_loc  out  LOC_W  smallest k achieving max_val

Behaviour:
- Reset (reset_n=0 at posedge): state S_IDLE; in_ready, busy and done = 0; max_val and max_loc = 0; all counters = 0. Reset mid-run abandons the run with no partial result.
- A beat transfers when in_valid && in_ready at posedge. in_valid while in_ready=0 is ignored; no data is lost or consumed.
- S_IDLE: in_ready=0. start -> S_LOAD_PAT.
- S_LOAD_PAT: in_ready=1. Each beat writes g[cnt]. After beat M-1 -> S_FILL; cnt clears.
- S_FILL: in_ready=1. Each beat shifts into a M-deep window register (newest at index M-1). After M beats -> S_MAC; sig_cnt = M.
- S_MAC: in_ready=0. Exactly M cycles; cycle i does acc += win[i]*g[i]. acc clears on entry. Then -> S_CMP.
- S_CMP: one cycle.
  - If k==0, or acc > max_val (strict, signedness per SIGNED): max_val<=acc, max_loc<=k. Ties keep the earlier k.
  - If k == N-M -> S_DONE; otherwise -> S_SHIFT with k<=k+1.
- S_SHIFT: in_ready=1. Waits for one beat, shifts the window by one, sig_cnt++, then -> S_MAC.
- S_DONE: done=1; max_val and max_loc held stable. start clears done (done=0 the next cycle) and enters S_LOAD_PAT. The pattern is always reloaded.
- start is ignored in all states other than S_IDLE and S_DONE.
- Throughput with in_valid held high: M+M cycles of loading, then (N-M+1)*(M+1) + (N-M) cycles. done rises the cycle after the final S_CMP.
- Extra in_data beyond N samples is never accepted because in_ready=0.
- Width rules:
  - Product is 2*DATA_W bits; the accumulator sign- or zero-extends it to ACC_W.
  - Overflow is impossible by construction of ACC_W.
  - SIGNED=0 uses unsigned compare and zero-extension throughout.

Decomposition:
- Package xcorr_pkg:
  - state enum (S_IDLE, S_LOAD_PAT, S_FILL, S_MAC, S_CMP, S_SHIFT, S_DONE)
  - width helper functions for ACC_W and LOC_W
- Sub-module xcorr_mac: a registered multiply-accumulate.
  - Parameters: DATA_W, ACC_W, SIGNED.
  - Inputs: clr, en, a, b.
  - Output: acc.
- The FSM, pattern RAM/regs, window and max tracking stay in xcorr_engine.

Test Plan:
- Basic peak: DATA_W=8, PAT_LEN=4, SIG_LEN=8, g=[1,2,3,4], f=[0,0,0,1,2,3,4,0] -> done, max_val=30, max_loc=3.
- All-negative: g=[1,1,1,1], f=[-1,-1,-1,-1,-5,-5,-5,-5] -> max_val=-4, max_loc=0. Checks that no zero initial max is used.
- Tie and extremes:
  - g=[1,0,0,0], f=[5,0,5,0,5,0,0,0] -> max_val=5, max_loc=0 (earliest of three ties).
  - All samples -128 -> max_val=65536, with no overflow.
- Backpressure: random in_valid gaps (about 50%) on the basic-peak data -> identical result. in_ready is never high in S_MAC or S_CMP, and no beat is lost.
- Reset and restart:
  - Assert reset_n=0 during S_MAC -> next cycle all outputs 0 and state S_IDLE.
  - A new full run then gives the correct result.
  - start in S_DONE with new data -> done drops, and the new result replaces the old.
- Default parameters (64/1024, SIGNED=1): random data vs. a software reference model -> max_val and max_loc match; total cycle count equals the formula.

Source files
------------

// File: rtl/xcorr_pkg.sv
// Shared types and width helpers for the streaming cross-correlation engine.
package xcorr_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_PAT,
    S_FILL,
    S_MAC,
    S_CMP,
    S_SHIFT,
    S_DONE
  } state_t;

  // Accumulator wide enough for PAT_LEN full-scale products without overflow.
  function automatic int acc_width(input int data_w, input int pat_len);
    return 2 * data_w + $clog2(pat_len) + 1;
  endfunction

  // Location width covering lags 0..SIG_LEN-PAT_LEN, plus one spare bit.
  function automatic int loc_width(input int sig_len, input int pat_len);
    return $clog2(sig_len - pat_len + 1) + 1;
  endfunction

endpackage

// File: rtl/xcorr_mac.sv
// Registered multiply-accumulate: acc <= acc + ext(a*b), signed or unsigned.
module xcorr_mac #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 23,
  parameter int SIGNED = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);

  logic [2*DATA_W-1:0] a_ext;
  logic [2*DATA_W-1:0] b_ext;
  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    prod_ext;

  // Operands are widened to the product width first so the low 2*DATA_W
  // bits of the multiply are the exact product in either number system.
  generate
    if (SIGNED != 0) begin : g_signed
      assign a_ext    = {{DATA_W{a[DATA_W-1]}}, a};
      assign b_ext    = {{DATA_W{b[DATA_W-1]}}, b};
      assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    end else begin : g_unsigned
      assign a_ext    = {{DATA_W{1'b0}}, a};
      assign b_ext    = {{DATA_W{1'b0}}, b};
      assign prod_ext = {{(ACC_W-2*DATA_W){1'b0}}, prod};
    end
  endgenerate

  assign prod = a_ext * b_ext;

  // Accumulator: clear has priority over accumulate.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + prod_ext;
    end
  end

endmodule

// File: rtl/xcorr_engine.sv
// Streaming cross-correlation engine: loads a pattern, slides it over a
// signal one lag at a time, and keeps the largest correlation and its lag.
module xcorr_engine
  import xcorr_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int PAT_LEN = 64,
  parameter int SIG_LEN = 1024,
  parameter int SIGNED  = 1,
  parameter int ACC_W   = acc_width(DATA_W, PAT_LEN),
  parameter int LOC_W   = loc_width(SIG_LEN, PAT_LEN)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  max_val,
  output logic [LOC_W-1:0]  max_loc
);

  localparam int CNT_W = $clog2(PAT_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAT_LEN - 1);
  localparam logic [LOC_W-1:0] K_LAST   = LOC_W'(SIG_LEN - PAT_LEN);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [LOC_W-1:0]   k;
  logic [DATA_W-1:0]  pat [PAT_LEN];
  logic [DATA_W-1:0]  win [PAT_LEN];

  logic               beat;
  logic               pat_we;
  logic               win_shift;
  logic               mac_clr;
  logic               mac_en;
  logic [DATA_W-1:0]  mac_a;
  logic [DATA_W-1:0]  mac_b;
  logic [ACC_W-1:0]   acc;
  logic               acc_gt;

  assign beat      = in_valid && in_ready;
  assign pat_we    = beat && (state == S_LOAD_PAT);
  assign win_shift = beat && ((state == S_FILL) || (state == S_SHIFT));
  // The accumulator is cleared on the beat that completes a window so it
  // starts from zero on the first S_MAC cycle.
  assign mac_clr   = beat && (((state == S_FILL) && (cnt == CNT_LAST)) ||
                              (state == S_SHIFT));
  assign mac_en    = (state == S_MAC);
  assign mac_a     = win[cnt];
  assign mac_b     = pat[cnt];

  generate
    if (SIGNED != 0) begin : g_cmp_signed
      assign acc_gt = $signed(acc) > $signed(max_val);
    end else begin : g_cmp_unsigned
      assign acc_gt = acc > max_val;
    end
  endgenerate

  xcorr_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .SIGNED (SIGNED)
  ) u_mac (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (mac_clr),
    .en      (mac_en),
    .a       (mac_a),
    .b       (mac_b),
    .acc     (acc)
  );

  // Pattern storage, written in index order during S_LOAD_PAT.
  always_ff @(posedge clk) begin
    if (pat_we) begin
      pat[cnt] <= in_data;
    end
  end

  // Signal window: oldest sample at index 0, newest enters at PAT_LEN-1.
  always_ff @(posedge clk) begin
    if (win_shift) begin
      for (int i = 0; i < PAT_LEN - 1; i++) begin
        win[i] <= win[i+1];
      end
      win[PAT_LEN-1] <= in_data;
    end
  end

  // Control FSM with registered handshake/status outputs and max tracking.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      max_val  <= '0;
      max_loc  <= '0;
      cnt      <= '0;
      k        <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state    <= S_LOAD_PAT;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            cnt      <= '0;
            k        <= '0;
          end
        end
        S_LOAD_PAT: begin
          if (beat) begin
            if (cnt == CNT_LAST) begin
              state <= S_FILL;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_FILL: begin
          if (beat) begin
            if (cnt == CNT_LAST) begin
              state    <= S_MAC;
              in_ready <= 1'b0;
              cnt      <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_MAC: begin
          if (cnt == CNT_LAST) begin
            state <= S_CMP;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_CMP: begin
          // Strict compare keeps the earliest lag on ties; lag 0 always seeds.
          if ((k == '0) || acc_gt) begin
            max_val <= acc;
            max_loc <= k;
          end
          if (k == K_LAST) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state    <= S_SHIFT;
            in_ready <= 1'b1;
            k        <= k + 1'b1;
          end
        end
        S_SHIFT: begin
          if (beat) begin
            state    <= S_MAC;
            in_ready <= 1'b0;
          end
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xcorr_engine.sv
// Self-checking bench: a small signed instance (4/8) for directed, backpressure
// and reset cases, and a default-size instance (64/1024) for a random run.
module tb_xcorr_engine;

  localparam int SW    = 8;
  localparam int SM    = 4;
  localparam int SN    = 8;
  localparam int S_ACC = 2*SW + $clog2(SM) + 1;
  localparam int S_LOC = $clog2(SN-SM+1) + 1;
  localparam int DM    = 64;
  localparam int DN    = 1024;
  localparam int D_ACC = 2*SW + $clog2(DM) + 1;
  localparam int D_LOC = $clog2(DN-DM+1) + 1;

  logic clk;
  logic reset_n;

  logic             s_start, s_valid, s_ready, s_busy, s_done;
  logic [SW-1:0]    s_data;
  logic [S_ACC-1:0] s_max_val;
  logic [S_LOC-1:0] s_max_loc;

  logic             d_start, d_valid, d_ready, d_busy, d_done;
  logic [SW-1:0]    d_data;
  logic [D_ACC-1:0] d_max_val;
  logic [D_LOC-1:0] d_max_loc;

  int checks = 0;
  int errors = 0;

  xcorr_engine #(.DATA_W(SW), .PAT_LEN(SM), .SIG_LEN(SN), .SIGNED(1)) dut_small (
    .clk(clk), .reset_n(reset_n), .start(s_start), .in_valid(s_valid),
    .in_data(s_data), .in_ready(s_ready), .busy(s_busy), .done(s_done),
    .max_val(s_max_val), .max_loc(s_max_loc)
  );

  xcorr_engine #(.DATA_W(SW), .PAT_LEN(DM), .SIG_LEN(DN), .SIGNED(1)) dut_default (
    .clk(clk), .reset_n(reset_n), .start(d_start), .in_valid(d_valid),
    .in_data(d_data), .in_ready(d_ready), .busy(d_busy), .done(d_done),
    .max_val(d_max_val), .max_loc(d_max_loc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Direct definition: C[k] = sum f[k+i]*g[i]; first k with the largest C.
  function automatic void ref_xcorr(input int g[$], input int f[$],
                                    output longint mv, output int ml);
    int m = g.size();
    int n = f.size();
    mv = 0;
    ml = 0;
    for (int kk = 0; kk <= n - m; kk++) begin
      longint c = 0;
      for (int i = 0; i < m; i++) c += longint'(f[kk+i]) * longint'(g[i]);
      if (kk == 0 || c > mv) begin
        mv = c;
        ml = kk;
      end
    end
  endfunction

  function automatic int cycles_expected(input int m, input int n);
    return 2*m + (n-m+1)*(m+1) + (n-m);
  endfunction

  // One run on the small instance. gap = percent of idle in_valid cycles;
  // abort_at > 0 stops driving after that many cycles (for the reset test).
  task automatic run_s(input string tag, input int g[SM], input int f[SN],
                       input int gap, input int abort_at, input bit chk_cyc);
    int     all[$];
    int     gq[$];
    int     fq[$];
    int     idx = 0;
    int     cyc = 0;
    int     total;
    bit     go;
    bit     viol = 0;
    longint mv;
    int     ml;
    for (int i = 0; i < SM; i++) begin all.push_back(g[i]); gq.push_back(g[i]); end
    for (int i = 0; i < SN; i++) begin all.push_back(f[i]); fq.push_back(f[i]); end
    total = all.size();
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    check({tag, ".done_low_after_start"}, longint'(s_done), 0);
    check({tag, ".busy_after_start"}, longint'(s_busy), 1);
    while (!s_done && cyc < 2000) begin
      if (abort_at != 0 && cyc == abort_at) break;
      if (idx < total) begin
        s_valid = ($urandom_range(99) >= gap);
        s_data  = 8'(all[idx]);
      end else begin
        s_valid = 1'b1;
        s_data  = 8'($urandom);
      end
      go = s_valid && s_ready;
      if (s_ready && !s_busy) viol = 1'b1;
      @(posedge clk); #1;
      if (go) idx++;
      cyc++;
    end
    s_valid = 1'b0;
    if (abort_at != 0) begin
      $display("run %s: aborted after %0d cycles, %0d beats", tag, cyc, idx);
      return;
    end
    ref_xcorr(gq, fq, mv, ml);
    $display("run %s: max_val=%0d max_loc=%0d cycles=%0d (ref %0d @ %0d)",
             tag, $signed(s_max_val), s_max_loc, cyc, mv, ml);
    check({tag, ".done"}, longint'(s_done), 1);
    check({tag, ".max_val"}, longint'($signed(s_max_val)), mv);
    check({tag, ".max_loc"}, longint'(s_max_loc), longint'(ml));
    check({tag, ".beats"}, longint'(idx), longint'(total));
    check({tag, ".ready_low_done"}, longint'(s_ready), 0);
    check({tag, ".ready_only_busy"}, longint'(viol), 0);
    if (chk_cyc) check({tag, ".cycles"}, longint'(cyc), longint'(cycles_expected(SM, SN)));
    // Results must hold while done and start is low.
    repeat (3) @(posedge clk);
    #1;
    check({tag, ".hold_val"}, longint'($signed(s_max_val)), mv);
  endtask

  // One run on the default instance with in_valid held high.
  task automatic run_d(input string tag);
    int     gq[$];
    int     fq[$];
    int     all[$];
    int     idx = 0;
    int     cyc = 0;
    bit     go;
    longint mv;
    int     ml;
    for (int i = 0; i < DM; i++) gq.push_back(int'($urandom_range(255)) - 128);
    for (int i = 0; i < DN; i++) fq.push_back(int'($urandom_range(255)) - 128);
    all = gq;
    for (int i = 0; i < DN; i++) all.push_back(fq[i]);
    d_start = 1'b1;
    @(posedge clk); #1;
    d_start = 1'b0;
    while (!d_done && cyc < 70000) begin
      d_valid = 1'b1;
      d_data  = (idx < all.size()) ? 8'(all[idx]) : 8'($urandom);
      go = d_valid && d_ready;
      @(posedge clk); #1;
      if (go) idx++;
      cyc++;
    end
    d_valid = 1'b0;
    ref_xcorr(gq, fq, mv, ml);
    $display("run %s: max_val=%0d max_loc=%0d cycles=%0d (ref %0d @ %0d)",
             tag, $signed(d_max_val), d_max_loc, cyc, mv, ml);
    check({tag, ".done"}, longint'(d_done), 1);
    check({tag, ".max_val"}, longint'($signed(d_max_val)), mv);
    check({tag, ".max_loc"}, longint'(d_max_loc), longint'(ml));
    check({tag, ".beats"}, longint'(idx), longint'(DM + DN));
    check({tag, ".cycles"}, longint'(cyc), longint'(cycles_expected(DM, DN)));
  endtask

  initial begin
    int g[SM];
    int f[SN];
    reset_n = 1'b0;
    s_start = 1'b0; s_valid = 1'b0; s_data = '0;
    d_start = 1'b0; d_valid = 1'b0; d_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.done", longint'(s_done), 0);
    check("reset.busy", longint'(s_busy), 0);
    check("reset.ready", longint'(s_ready), 0);
    check("reset.max_val", longint'(s_max_val), 0);
    check("reset.max_loc", longint'(s_max_loc), 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    g = '{1, 2, 3, 4};
    f = '{0, 0, 0, 1, 2, 3, 4, 0};
    run_s("peak", g, f, 0, 0, 1'b1);
    check("peak.const_val", longint'($signed(s_max_val)), 30);
    check("peak.const_loc", longint'(s_max_loc), 3);

    g = '{1, 1, 1, 1};
    f = '{-1, -1, -1, -1, -5, -5, -5, -5};
    run_s("allneg", g, f, 0, 0, 1'b1);
    check("allneg.const_val", longint'($signed(s_max_val)), -4);

    g = '{1, 0, 0, 0};
    f = '{5, 0, 5, 0, 5, 0, 0, 0};
    run_s("tie", g, f, 0, 0, 1'b1);
    check("tie.const_loc", longint'(s_max_loc), 0);

    g = '{-128, -128, -128, -128};
    f = '{-128, -128, -128, -128, -128, -128, -128, -128};
    run_s("min128", g, f, 0, 0, 1'b1);
    check("min128.const_val", longint'($signed(s_max_val)), 65536);

    g = '{1, 2, 3, 4};
    f = '{0, 0, 0, 1, 2, 3, 4, 0};
    run_s("backpr", g, f, 50, 0, 1'b0);
    check("backpr.const_val", longint'($signed(s_max_val)), 30);

    // Abandon a run while in S_MAC (edge 2M+2 after start) and reset it.
    for (int i = 0; i < SM; i++) g[i] = int'($urandom_range(255)) - 128;
    for (int i = 0; i < SN; i++) f[i] = int'($urandom_range(255)) - 128;
    run_s("abort", g, f, 0, 2*SM + 2, 1'b0);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("midrst.done", longint'(s_done), 0);
    check("midrst.busy", longint'(s_busy), 0);
    check("midrst.ready", longint'(s_ready), 0);
    check("midrst.max_val", longint'(s_max_val), 0);
    check("midrst.max_loc", longint'(s_max_loc), 0);
    @(posedge clk); #1;
    run_s("after_rst", g, f, 0, 0, 1'b1);

    // Back-to-back restarts from S_DONE with fresh random data.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < SM; i++) g[i] = int'($urandom_range(255)) - 128;
      for (int i = 0; i < SN; i++) f[i] = int'($urandom_range(255)) - 128;
      run_s($sformatf("rand%0d", r), g, f, 30, 0, 1'b0);
    end

    run_d("default");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
